// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//
// LIFO stack with a registered top-of-stack and a sticky error state.
// The top entry lives in its own register (o_top) so a POP returns the
// popped word with zero latency: the value is simply o_top in the POP cycle.
// The lower DEPTH-1 entries live in an array indexed by count-2, and the
// entry directly under the top is always at index count-2.
//
// A PUSH on a full stack, or a POP/REPLACE on an empty stack, sets the
// matching sticky flag and moves the unit to ERR. In ERR every operation is
// ignored until i_clear_err, which clears both flags and returns to RUN.
// The operation presented in that same cycle is dropped.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  maximum number of entries (power of two, >= 2)
//   CW     count width, log2(DEPTH)+1 (derived)
//
// Ports
//   i_clock      clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_op         00 NOP, 01 PUSH, 10 POP, 11 REPLACE (overwrite top)
//   i_data       word for PUSH / REPLACE
//   i_clear_err  leave ERR, clear sticky flags
//   o_top        current top of stack (0 when empty)
//   o_count      number of valid entries, 0..DEPTH
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
//   o_overflow   sticky, set by PUSH when full
//   o_underflow  sticky, set by POP or REPLACE when empty
//   o_err        high while in ERR
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear_err,
    output logic [WIDTH-1:0] o_top,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_err
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_TWO    = CW'(2);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   top_q, top_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Storage for the entries below the top; never reset, since an entry is
    // always written before count can make it readable.
    logic [WIDTH-1:0]   mem_q [DEPTH-1];

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [AW-1:0]      mem_raddr;
    logic [WIDTH-1:0]   mem_rdata;
    logic [CW-1:0]      count_m1;
    logic [CW-1:0]      count_m2;
    logic               is_empty;
    logic               is_full;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == FULL_COUNT);
    assign count_m1  = count_q - CNT_ONE;
    assign count_m2  = count_q - CNT_TWO;
    // The truncated address is only meaningful when the matching access
    // is actually enabled (count >= 1 for writes, count >= 2 for reads).
    assign mem_waddr = count_m1[AW-1:0];
    assign mem_raddr = count_m2[AW-1:0];
    assign mem_rdata = mem_q[mem_raddr];

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_RUN: begin
                // i_clear_err is deliberately ignored in RUN.
                case (i_op)
                    OP_PUSH: begin
                        if (is_full) begin
                            ovf_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            // Current top sinks into the array, but only if
                            // there is a real top to preserve.
                            mem_we  = !is_empty;
                            top_d   = i_data;
                            count_d = count_q + CNT_ONE;
                        end
                    end
                    OP_POP: begin
                        if (is_empty) begin
                            unf_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            // Popping the last entry leaves the top at zero.
                            top_d   = (count_q >= CNT_TWO) ? mem_rdata : '0;
                            count_d = count_m1;
                        end
                    end
                    OP_REPLACE: begin
                        if (is_empty) begin
                            unf_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            top_d = i_data;
                        end
                    end
                    default: ; // OP_NOP
                endcase
            end
            ST_ERR: begin
                if (i_clear_err) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (mem_we && !i_reset) begin
            mem_q[mem_waddr] <= top_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_top       = top_q;
    assign o_count     = count_q;
    assign o_empty     = is_empty;
    assign o_full      = is_full;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_err       = (state_q == ST_ERR);

    // OP_NOP is named for readability only.
    logic unused_nop;
    assign unused_nop = ^OP_NOP;

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//
// Directed test of stack_unit (WIDTH=16, DEPTH=4). The stimulus process drives
// one operation per cycle and queues the hand-computed state expected after
// that clock edge (plus the popped word for POPs). A separate monitor pops the
// queue once per cycle and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] PSH = 2'b01;
    localparam logic [1:0] POP = 2'b10;
    localparam logic [1:0] RPL = 2'b11;

    logic             clk;
    logic             rst;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic             clr;
    logic [WIDTH-1:0] o_top;
    logic [CW-1:0]    o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_overflow;
    logic             o_underflow;
    logic             o_err;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_op        (op),
        .i_data      (data),
        .i_clear_err (clr),
        .o_top       (o_top),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] top;
        logic [CW-1:0]    count;
        logic             ovf;
        logic             unf;
        logic             err;
        bit               is_pop;
        logic [WIDTH-1:0] pop_val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle of stimulus and queue what the DUT must show afterwards.
    task automatic step(input string nm, input logic r, input logic [1:0] o,
                        input logic [WIDTH-1:0] d, input logic c,
                        input logic [WIDTH-1:0] e_top, input int e_cnt,
                        input logic e_ovf, input logic e_unf, input logic e_err,
                        input bit is_pop, input logic [WIDTH-1:0] pop_val);
        exp_t e;
        @(negedge clk);
        rst  = r;
        op   = o;
        data = d;
        clr  = c;
        e.name    = nm;
        e.top     = e_top;
        e.count   = CW'(e_cnt);
        e.ovf     = e_ovf;
        e.unf     = e_unf;
        e.err     = e_err;
        e.is_pop  = is_pop;
        e.pop_val = pop_val;
        exp_q.push_back(e);
    endtask

    // Monitor: the popped word is o_top before the edge; state is after it.
    initial begin : monitor
        logic [WIDTH-1:0] pre_top;
        logic [WIDTH+CW+4:0] act, req;
        exp_t e;
        forever begin
            @(negedge clk);
            pre_top = o_top;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.is_pop) begin
                    checks++;
                    if (pre_top !== e.pop_val) begin
                        failures++;
                        $display("FAIL %s popped: got %h expected %h", e.name, pre_top, e.pop_val);
                    end
                end
                act = {o_top, o_count, o_empty, o_full, o_overflow, o_underflow, o_err};
                req = {e.top, e.count, (e.count == 0), (e.count == CW'(DEPTH)), e.ovf, e.unf, e.err};
                checks++;
                if (act !== req) begin
                    failures++;
                    $display("FAIL %s: got top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b err=%b expected top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b err=%b",
                             e.name, o_top, o_count, o_empty, o_full, o_overflow, o_underflow, o_err,
                             e.top, e.count, (e.count == 0), (e.count == CW'(DEPTH)), e.ovf, e.unf, e.err);
                end else begin
                    $display("ok   %s: top=%h cnt=%0d ovf=%b unf=%b err=%b", e.name,
                             o_top, o_count, o_overflow, o_underflow, o_err);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst = 1'b1; op = NOP; data = '0; clr = 1'b0;

        //    name            rst  op   data     clr  top      cnt ovf unf err pop pop_val
        step("reset",         1, NOP, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        step("push1111",      0, PSH, 16'h1111, 0, 16'h1111, 1, 0, 0, 0, 0, 16'h0000);
        step("push2222",      0, PSH, 16'h2222, 0, 16'h2222, 2, 0, 0, 0, 0, 16'h0000);
        step("push3333",      0, PSH, 16'h3333, 0, 16'h3333, 3, 0, 0, 0, 0, 16'h0000);
        step("push4444",      0, PSH, 16'h4444, 0, 16'h4444, 4, 0, 0, 0, 0, 16'h0000);
        step("nop_full",      0, NOP, 16'hFFFF, 0, 16'h4444, 4, 0, 0, 0, 0, 16'h0000);
        step("push_ovf",      0, PSH, 16'hAAAA, 0, 16'h4444, 4, 1, 0, 1, 0, 16'h0000);
        step("push_in_err",   0, PSH, 16'hBBBB, 0, 16'h4444, 4, 1, 0, 1, 0, 16'h0000);
        step("clr_drops_pop", 0, POP, 16'h0000, 1, 16'h4444, 4, 0, 0, 0, 0, 16'h0000);
        step("clr_in_run",    0, POP, 16'h0000, 1, 16'h3333, 3, 0, 0, 0, 1, 16'h4444);
        step("repush4444",    0, PSH, 16'h4444, 0, 16'h4444, 4, 0, 0, 0, 0, 16'h0000);
        step("pop4",          0, POP, 16'h0000, 0, 16'h3333, 3, 0, 0, 0, 1, 16'h4444);
        step("pop3",          0, POP, 16'h0000, 0, 16'h2222, 2, 0, 0, 0, 1, 16'h3333);
        step("pop2",          0, POP, 16'h0000, 0, 16'h1111, 1, 0, 0, 0, 1, 16'h2222);
        step("pop1",          0, POP, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h1111);
        step("pop_unf",       0, POP, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000);
        step("rpl_in_err",    0, RPL, 16'h5555, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000);
        step("clr_unf",       0, NOP, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        step("rpl_unf",       0, RPL, 16'h5555, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000);
        step("reset_in_err",  1, PSH, 16'h7777, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        step("push1234",      0, PSH, 16'h1234, 0, 16'h1234, 1, 0, 0, 0, 0, 16'h0000);
        step("rpl_beef",      0, RPL, 16'hBEEF, 0, 16'hBEEF, 1, 0, 0, 0, 0, 16'h0000);
        step("pop_beef",      0, POP, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hBEEF);
        step("push0001",      0, PSH, 16'h0001, 0, 16'h0001, 1, 0, 0, 0, 0, 16'h0000);
        step("push0002",      0, PSH, 16'h0002, 0, 16'h0002, 2, 0, 0, 0, 0, 16'h0000);
        step("reset_w_push",  1, PSH, 16'h0003, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        step("push0005",      0, PSH, 16'h0005, 0, 16'h0005, 1, 0, 0, 0, 0, 16'h0000);
        step("push0006",      0, PSH, 16'h0006, 0, 16'h0006, 2, 0, 0, 0, 0, 16'h0000);
        step("rpl0007",       0, RPL, 16'h0007, 0, 16'h0007, 2, 0, 0, 0, 0, 16'h0000);
        step("pop0007",       0, POP, 16'h0000, 0, 16'h0005, 1, 0, 0, 0, 1, 16'h0007);
        step("idle",          0, NOP, 16'h0000, 0, 16'h0005, 1, 0, 0, 0, 0, 16'h0000);

        // Let the monitor drain the queue, bounded.
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
